// File: rtl/md_arbiter.sv
// rtl/md_arbiter.sv - round-robin arbiter/sequencer sharing one multiply/divide unit
//
// Two requesters present operations through a valid/ready handshake. The
// granted operation is latched, issued to the MD unit, tracked through the
// unit's busy window and completed with a one-cycle done pulse that is tagged
// with the requester id.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   rX_valid/op/a/b/ready    requester X operation handshake (X = 0, 1)
//   done, done_id            completion pulse and owning requester
//   res_hi, res_lo, res_rd   captured HI/LO (mult/div) and mfhi/mflo data
//   arb_busy                 operation in flight
//   md_start/op/a/b          command to the MD unit
//   md_busy/hi/lo/out        status and results from the MD unit
module md_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         r0_valid,
  input  logic [3:0]   r0_op,
  input  logic [W-1:0] r0_a,
  input  logic [W-1:0] r0_b,
  output logic         r0_ready,
  input  logic         r1_valid,
  input  logic [3:0]   r1_op,
  input  logic [W-1:0] r1_a,
  input  logic [W-1:0] r1_b,
  output logic         r1_ready,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] res_hi,
  output logic [W-1:0] res_lo,
  output logic [W-1:0] res_rd,
  output logic         arb_busy,
  output logic         md_start,
  output logic [3:0]   md_op,
  output logic [W-1:0] md_a,
  output logic [W-1:0] md_b,
  input  logic         md_busy,
  input  logic [W-1:0] md_hi,
  input  logic [W-1:0] md_lo,
  input  logic [W-1:0] md_out
);

  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RUN, S_DONE} state_t;

  state_t state;
  logic   ptr;        // 0: r0 wins a tie, 1: r1 wins a tie
  logic   lat_id;
  logic   seen_busy;
  logic   grant0;
  logic   grant1;
  logic [3:0]   sel_op;
  logic [W-1:0] sel_a;
  logic [W-1:0] sel_b;

  function automatic logic is_long(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mf(input logic [3:0] op);
    return (op == MD_MFHI) || (op == MD_MFLO);
  endfunction

  // Grants only in IDLE; a reset cycle suppresses any grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == S_IDLE && !reset) begin
      if (r0_valid && (!r1_valid || !ptr)) grant0 = 1'b1;
      else if (r1_valid)                   grant1 = 1'b1;
    end
  end

  always_comb begin
    sel_op = grant1 ? r1_op : r0_op;
    sel_a  = grant1 ? r1_a  : r0_a;
    sel_b  = grant1 ? r1_b  : r0_b;
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;
  assign arb_busy = (state != S_IDLE);

  // md_op/md_a/md_b double as the operand latch while an operation is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= 1'b0;
      lat_id    <= 1'b0;
      seen_busy <= 1'b0;
      done      <= 1'b0;
      done_id   <= 1'b0;
      res_hi    <= '0;
      res_lo    <= '0;
      res_rd    <= '0;
      md_start  <= 1'b0;
      md_op     <= MD_MFHI;
      md_a      <= '0;
      md_b      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (grant0 || grant1) begin
            md_op     <= sel_op;
            md_a      <= sel_a;
            md_b      <= sel_b;
            lat_id    <= grant1;
            ptr       <= grant0;
            md_start  <= is_long(sel_op);
            seen_busy <= 1'b0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          md_start <= 1'b0;
          if (is_long(md_op)) begin
            state <= S_RUN;
          end else begin
            // Move-to ops are written by the MD unit at this same edge.
            if (is_mf(md_op)) res_rd <= md_out;
            done    <= 1'b1;
            done_id <= lat_id;
            state   <= S_DONE;
          end
        end
        S_RUN: begin
          if (md_busy) seen_busy <= 1'b1;
          // Wait for the busy window to open and close before sampling HI/LO.
          if (seen_busy && !md_busy) begin
            res_hi  <= md_hi;
            res_lo  <= md_lo;
            done    <= 1'b1;
            done_id <= lat_id;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          md_op <= MD_MFHI;
          md_a  <= '0;
          md_b  <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
